// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing constants and helpers; default mode is 800x600@60 from 240 MHz / 6.
package vga_pkg;
    localparam int unsigned VGA_CW        = 11;
    localparam int unsigned VGA_TICK_DIV  = 6;
    localparam int unsigned VGA_H_VISIBLE = 800;
    localparam int unsigned VGA_H_FP      = 40;
    localparam int unsigned VGA_H_SYNC    = 128;
    localparam int unsigned VGA_H_BP      = 88;
    localparam int unsigned VGA_V_VISIBLE = 600;
    localparam int unsigned VGA_V_FP      = 1;
    localparam int unsigned VGA_V_SYNC    = 4;
    localparam int unsigned VGA_V_BP      = 23;

    function automatic int unsigned axis_total(input int unsigned vis, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return vis + fp + sync + bp;
    endfunction

    localparam int unsigned VGA_H_TOTAL = axis_total(VGA_H_VISIBLE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
    localparam int unsigned VGA_V_TOTAL = axis_total(VGA_V_VISIBLE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);
endpackage

// File: rtl/vga_timing_gen_axis.sv
// vga_axis_counter: one raster axis, wrapping counter plus registered sync and next-state visible decode.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned VISIBLE = VGA_H_VISIBLE,
    parameter int unsigned FP      = VGA_H_FP,
    parameter int unsigned SYNC    = VGA_H_SYNC,
    parameter int unsigned BP      = VGA_H_BP,
    parameter bit          POL     = 1'b1,
    parameter int unsigned CW      = VGA_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce_i,
    input  logic          clr_i,
    output logic [CW-1:0] count_o,
    output logic [CW-1:0] count_d_o,
    output logic          last_o,
    output logic          vis_d_o,
    output logic          sync_o
);
    localparam int unsigned TOTAL = axis_total(VISIBLE, FP, SYNC, BP);
    localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);
    localparam logic [CW-1:0] VIS  = CW'(VISIBLE);
    localparam logic [CW-1:0] S0   = CW'(VISIBLE + FP);
    localparam logic [CW-1:0] S1   = CW'(VISIBLE + FP + SYNC - 1);

    logic [CW-1:0] count_q, count_d;
    logic          sync_q, sync_d;

    always_comb begin
        count_d = clr_i ? '0 : !ce_i ? count_q : (count_q == LAST) ? '0 : count_q + 1'b1;
        sync_d  = (count_d >= S0 && count_d <= S1) ? POL : !POL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            sync_q  <= !POL;
        end else begin
            count_q <= count_d;
            sync_q  <= sync_d;
        end
    end

    assign count_o   = count_q;
    assign count_d_o = count_d;
    assign last_o    = count_q == LAST;
    assign vis_d_o   = count_d < VIS;
    assign sync_o    = sync_q;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with pixel enable, genlock restart and line/frame strobes.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned TICK_DIV  = VGA_TICK_DIV,
    parameter int unsigned H_VISIBLE = VGA_H_VISIBLE,
    parameter int unsigned H_FP      = VGA_H_FP,
    parameter int unsigned H_SYNC    = VGA_H_SYNC,
    parameter int unsigned H_BP      = VGA_H_BP,
    parameter int unsigned V_VISIBLE = VGA_V_VISIBLE,
    parameter int unsigned V_FP      = VGA_V_FP,
    parameter int unsigned V_SYNC    = VGA_V_SYNC,
    parameter int unsigned V_BP      = VGA_V_BP,
    parameter bit          HSYNC_POL = 1'b1,
    parameter bit          VSYNC_POL = 1'b1,
    parameter int unsigned CW        = VGA_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          restart,
    output logic          pix_ce,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic          visible,
    output logic          hsync,
    output logic          vsync,
    output logic          line_start,
    output logic          frame_start,
    output logic          vblank_start
);
    localparam int unsigned DW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;

    logic [DW-1:0] div_q, div_d;
    logic [CW-1:0] h_d, v_d;
    logic          tick, load, pend_q, pend_d, h_last, h_vis_d, v_vis_d;
    logic          pix_ce_q, visible_q, line_q, frame_q, vblank_q;

    // tick marks the edge that advances the raster; pix_ce is its registered image
    always_comb begin
        tick   = div_q == DW'(TICK_DIV - 1);
        div_d  = tick ? '0 : div_q + 1'b1;
        load   = tick && (pend_q || restart);
        pend_d = !load && (pend_q || restart);
    end

    vga_axis_counter #(
        .VISIBLE(H_VISIBLE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HSYNC_POL), .CW(CW)
    ) u_h (
        .clk(clk), .rst(rst), .ce_i(tick), .clr_i(load),
        .count_o(hcount), .count_d_o(h_d), .last_o(h_last), .vis_d_o(h_vis_d), .sync_o(hsync)
    );

    vga_axis_counter #(
        .VISIBLE(V_VISIBLE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VSYNC_POL), .CW(CW)
    ) u_v (
        .clk(clk), .rst(rst), .ce_i(tick && h_last), .clr_i(load),
        .count_o(vcount), .count_d_o(v_d), .last_o(), .vis_d_o(v_vis_d), .sync_o(vsync)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q     <= '0;
            pend_q    <= 1'b0;
            pix_ce_q  <= 1'b0;
            visible_q <= 1'b1;
            line_q    <= 1'b0;
            frame_q   <= 1'b0;
            vblank_q  <= 1'b0;
        end else begin
            div_q     <= div_d;
            pend_q    <= pend_d;
            pix_ce_q  <= tick;
            visible_q <= h_vis_d && v_vis_d;
            line_q    <= tick && h_d == '0;
            frame_q   <= tick && h_d == '0 && v_d == '0;
            vblank_q  <= tick && h_d == '0 && v_d == CW'(V_VISIBLE);
        end
    end

    assign pix_ce       = pix_ce_q;
    assign visible      = visible_q;
    assign line_start   = line_q;
    assign frame_start  = frame_q;
    assign vblank_start = vblank_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: four configurations checked each clock against a linear pixel-index raster model.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic restart = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    wire [3:0]  pce, vis, hs, vs, ls, fs, vb;
    wire [3:0]  hc0, vc0, hc1, vc1, hc3, vc3;
    wire [10:0] hc2, vc2;

    vga_timing_gen #(.TICK_DIV(3), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CW(4)) d0 (
        .clk(clk), .rst(rst), .restart(restart), .pix_ce(pce[0]), .hcount(hc0), .vcount(vc0),
        .visible(vis[0]), .hsync(hs[0]), .vsync(vs[0]), .line_start(ls[0]), .frame_start(fs[0]),
        .vblank_start(vb[0]));

    vga_timing_gen #(.TICK_DIV(3), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CW(4)) d1 (
        .clk(clk), .rst(rst), .restart(restart), .pix_ce(pce[1]), .hcount(hc1), .vcount(vc1),
        .visible(vis[1]), .hsync(hs[1]), .vsync(vs[1]), .line_start(ls[1]), .frame_start(fs[1]),
        .vblank_start(vb[1]));

    vga_timing_gen d2 (
        .clk(clk), .rst(rst), .restart(restart), .pix_ce(pce[2]), .hcount(hc2), .vcount(vc2),
        .visible(vis[2]), .hsync(hs[2]), .vsync(vs[2]), .line_start(ls[2]), .frame_start(fs[2]),
        .vblank_start(vb[2]));

    vga_timing_gen #(.TICK_DIV(1), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CW(4)) d3 (
        .clk(clk), .rst(rst), .restart(restart), .pix_ce(pce[3]), .hcount(hc3), .vcount(vc3),
        .visible(vis[3]), .hsync(hs[3]), .vsync(vs[3]), .line_start(ls[3]), .frame_start(fs[3]),
        .vblank_start(vb[3]));

    int td[4]  = '{3, 3, 6, 1};
    int hv[4]  = '{8, 8, 800, 8};
    int hfp[4] = '{2, 2, 40, 2};
    int hsw[4] = '{3, 3, 128, 3};
    int hbp[4] = '{2, 2, 88, 2};
    int vv[4]  = '{4, 4, 600, 4};
    int vfp[4] = '{1, 1, 1, 1};
    int vsw[4] = '{2, 2, 4, 2};
    int vbp[4] = '{1, 1, 23, 1};
    int pol[4] = '{1, 0, 1, 1};

    int cyc[4];
    int pos[4];
    bit pend[4];
    bit ece[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            if (failures <= 40) $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // model: raster position is a single pixel index advanced every td-th clock since reset
    task automatic step();
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            int ht = hv[k] + hfp[k] + hsw[k] + hbp[k];
            int vt = vv[k] + vfp[k] + vsw[k] + vbp[k];
            if (rst) begin
                cyc[k] = 0; pos[k] = 0; pend[k] = 1'b0; ece[k] = 1'b0;
            end else begin
                cyc[k]++;
                ece[k] = (cyc[k] % td[k]) == 0;
                if (ece[k] && (pend[k] || restart)) begin
                    pos[k] = 0; pend[k] = 1'b0;
                end else if (ece[k]) pos[k] = (pos[k] + 1) % (ht * vt);
                else pend[k] = pend[k] || restart;
            end
        end
        #1;
        for (int k = 0; k < 4; k++) begin
            int ht = hv[k] + hfp[k] + hsw[k] + hbp[k];
            int h = pos[k] % ht;
            int v = pos[k] / ht;
            bit hin = h >= hv[k] + hfp[k] && h < hv[k] + hfp[k] + hsw[k];
            bit vin = v >= vv[k] + vfp[k] && v < vv[k] + vfp[k] + vsw[k];
            string p = $sformatf("d%0d.", k);
            logic [10:0] oh, ov;
            case (k)
                0: begin oh = 11'(hc0); ov = 11'(vc0); end
                1: begin oh = 11'(hc1); ov = 11'(vc1); end
                2: begin oh = hc2; ov = vc2; end
                default: begin oh = 11'(hc3); ov = 11'(vc3); end
            endcase
            chk({p, "pix_ce"}, 32'(pce[k]), 32'(ece[k]));
            chk({p, "hcount"}, 32'(oh), h);
            chk({p, "vcount"}, 32'(ov), v);
            chk({p, "visible"}, 32'(vis[k]), 32'(h < hv[k] && v < vv[k]));
            chk({p, "hsync"}, 32'(hs[k]), hin ? pol[k] : 1 - pol[k]);
            chk({p, "vsync"}, 32'(vs[k]), vin ? pol[k] : 1 - pol[k]);
            chk({p, "line_start"}, 32'(ls[k]), 32'(ece[k] && h == 0));
            chk({p, "frame_start"}, 32'(fs[k]), 32'(ece[k] && pos[k] == 0));
            chk({p, "vblank_start"}, 32'(vb[k]), 32'(ece[k] && h == 0 && v == vv[k]));
        end
    endtask

    task automatic wait_at(input int h, input int v);
        int n = 0;
        while (!(pce[0] && int'(hc0) == h && int'(vc0) == v) && n < 1000) begin
            step();
            n++;
        end
        chk("wait_reached", 32'(n < 1000), 1);
    endtask

    initial begin
        rst = 1'b1;
        repeat (5) step();
        rst = 1'b0;
        repeat (7000) step();
        wait_at(5, 2);
        restart = 1'b1; step(); restart = 1'b0;
        repeat (400) step();
        wait_at(14, 7);
        restart = 1'b1; step(); restart = 1'b0;
        repeat (60) step();
        wait_at(9, 5);
        restart = 1'b1; step(); restart = 1'b0;
        rst = 1'b1; step(); rst = 1'b0;
        repeat (400) step();
        repeat (6000) begin
            restart = $urandom_range(0, 29) == 0;
            rst = $urandom_range(0, 399) == 0;
            step();
        end
        rst = 1'b0;
        restart = 1'b0;
        repeat (20) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
